// File: rtl/tmp8_pkg.sv
// Shared defaults for the tmp8 pipeline register slice.
package tmp8_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 2;

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline slot: a valid flag plus a data word that only loads when a word arrives.
module pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  logic             advance,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Loading wins over advancing so a word can pass through while this slot refills.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (advance) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_reg.sv
// Compacting valid/ready register pipeline of DEPTH stages with flush and occupancy count.
module pipe_reg
   import tmp8_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] stage_adv;
   logic [DEPTH-1:0] stage_load;
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [WIDTH-1:0] stage_din  [DEPTH];
   logic             drain_ok;
   logic             in_xfer;
   logic             out_xfer;

   assign drain_ok = out_ready && !flush && !reset;

   // A stage may move on if any slot ahead of it is free or the tail is draining;
   // written as a scan over valid bits so the chain has no self-referencing vector.
   always_comb begin
      stage_adv = '0;
      for (int i = 0; i < DEPTH; i++) begin
         stage_adv[i] = drain_ok;
         for (int j = i + 1; j < DEPTH; j++) begin
            if (!stage_valid[j]) stage_adv[i] = 1'b1;
         end
      end
   end

   assign in_ready  = (!stage_valid[0] || stage_adv[0]) && !flush && !reset;
   assign out_valid = stage_valid[DEPTH-1] && !flush && !reset;
   assign out_data  = stage_data[DEPTH-1];
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      stage_load    = '0;
      stage_load[0] = in_xfer;
      stage_din[0]  = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         stage_load[i] = stage_valid[i-1] && stage_adv[i-1];
         stage_din[i]  = stage_data[i-1];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      pipe_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .load     (stage_load[g]),
         .advance  (stage_adv[g]),
         .load_data(stage_din[g]),
         .valid    (stage_valid[g]),
         .data     (stage_data[g])
      );
   end

   // Occupancy tracks transfers rather than re-counting valid bits.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count <= '0;
      end else if (in_xfer && !out_xfer) begin
         count <= count + CW'(1);
      end else if (out_xfer && !in_xfer) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 8, data bits per word; legal range 1..64.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 flush  input  1  synchronous discard of all held words.
REQ-006 in_valid  input  1  upstream word present on in_data.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 out_valid  output  1  word present on out_data.
REQ-010 out_ready  input  1  downstream accepts word this cycle.
REQ-011 out_data  output  WIDTH  word held in the last stage.
REQ-012 count  output  $clog2(DEPTH+1)  number of stages currently holding a valid word.

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold a valid bit and a WIDTH-bit data register; stage 0 faces input, stage DEPTH-1 drives out_data/out_valid.
REQ-014 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-015 Stage DEPTH-1 SHALL advance (release its word) when out_ready is high; stage i<DEPTH-1 SHALL advance when stage i+1 is empty or stage i+1 advances in the same cycle.
REQ-016 in_ready SHALL equal (stage 0 empty || stage 0 advances) && !flush; it is combinational from out_ready through the stage chain.
REQ-017 A word accepted on edge N with no back-pressure SHALL be presented on out_data with out_valid high in the cycle after edge N+DEPTH-1 (DEPTH=1: cycle after edge N).
REQ-018 With out_ready held high and in_valid held high, the block SHALL accept one word per cycle and deliver one word per cycle after the fill latency (full throughput, no bubbles).
REQ-019 Words SHALL leave in acceptance order; no word is duplicated, dropped or reordered except by flush or reset.
REQ-020 When out_ready is low, words SHALL compact forward into empty stages; in_ready falls only when all DEPTH stages are valid and the last stage does not advance.
REQ-021 A stage's data register SHALL load only when it receives a word; otherwise it holds its value (no toggling of idle data).
REQ-022 count SHALL be registered, equal to the popcount of stage valid bits, incrementing on input-only transfers, decrementing on output-only transfers, unchanged when both or neither occur.
REQ-023 count SHALL never exceed DEPTH nor wrap below 0.
REQ-024 When flush is high, out_valid SHALL be forced low in that cycle, no transfer occurs on either side, and on the next edge all valid bits and count SHALL clear; data registers keep their values.
REQ-025 out_data SHALL be undefined-free: it always shows the last-stage data register, including when out_valid is low.

Reset
REQ-026 On a rising edge with reset high, all valid bits, all data registers and count SHALL become 0; reset overrides flush and any transfer in that cycle.
REQ-027 While reset is high, in_ready and out_valid SHALL be 0 in the same cycle.
REQ-028 First input accepted on the first edge after reset deasserts if in_valid is high.

Structure
REQ-029 Default WIDTH/DEPTH constants SHALL live in shared package tmp8_pkg; count width derives locally via $clog2.
REQ-030 One sub-module pipe_stage (valid bit + WIDTH data register + advance/load logic) SHALL be instantiated DEPTH times via generate.

Verification
REQ-031 Reset: reset=1 for 2 cycles with in_valid=1, in_data=8'hA5 -> in_ready=0, out_valid=0, count=0, out_data=8'h00.
REQ-032 Latency, DEPTH=2: accept 8'h3C at edge 5, out_ready=1 -> out_valid=1, out_data=8'h3C in cycle after edge 6 only.
REQ-033 Throughput: stream 8'h01..8'h10 back-to-back, out_ready=1 -> 16 outputs in order on 16 consecutive cycles, count steady at 2.
REQ-034 Back-pressure: out_ready=0, offer 8'h11,8'h22,8'h33 -> first two accepted, in_ready=0, count=2; raise out_ready -> 8'h11,8'h22,8'h33 delivered in order.
REQ-035 Flush: pipe full (count=2), assert flush with in_valid=1 -> out_valid=0, no acceptance that cycle, count=0 after edge, next word 8'h44 is first delivered.
REQ-036 Reset mid-stream with flush=1 and both handshakes active -> all cleared, no word delivered afterwards without new input.
